// File: rtl/ib_scan_ctrl.sv
// ib_scan_ctrl: frame scan sequencer for the input buffer.
// Walks the 3x3 window over an N x N output map in row-major order,
// hands positions downstream over valid/ready, and drives the ctrl_reset /
// ctrl_update pulses for the downstream 6:1 row-mux controller.
// Optional feature: define IB_SCAN_STALL_CNT_EN to build the backpressure
// stall counter on stall_cnt_o (tied to zero otherwise).
module ib_scan_ctrl #(
    parameter int DIM_W   = 6,
    parameter int STALL_W = 16
) (
    input  logic               SYS_CLK,
    input  logic               SYS_NRST,
    input  logic               start_i,
    input  logic [3:0]         mode_i,
    input  logic [DIM_W-1:0]   pic_size_i,
    input  logic               padding_i,
    input  logic               win_ready_i,
    output logic               win_valid_o,
    output logic [DIM_W-1:0]   row_o,
    output logic [DIM_W-1:0]   col_o,
    output logic               pad_o,
    output logic [3:0]         mode_o,
    output logic               ctrl_reset_o,
    output logic               ctrl_update_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [DIM_W:0]   last_reg;      // N-1 of the latched frame
    logic             padding_reg;

    logic [DIM_W:0]   cfg_sum;       // pic_size + 2*padding, one bit wider
    logic             cfg_ok;
    logic [DIM_W:0]   last_next;     // N-1 = pic_size - 3 + 2*padding
    logic             row_last;
    logic             col_last;
    logic [DIM_W-1:0] row_inc;
    logic [DIM_W-1:0] col_inc;
    logic             transfer;

    // Configuration arithmetic and counter wrap detection.
    always_comb begin
        cfg_sum   = {1'b0, pic_size_i} + {{(DIM_W-1){1'b0}}, padding_i, 1'b0};
        cfg_ok    = (cfg_sum >= (DIM_W+1)'(3));
        last_next = cfg_sum - (DIM_W+1)'(3);
        row_last  = ({1'b0, row_o} == last_reg);
        col_last  = ({1'b0, col_o} == last_reg);
        row_inc   = row_o + DIM_W'(1);
        col_inc   = col_o + DIM_W'(1);
        transfer  = win_valid_o & win_ready_i;
    end

    // Border test for a window position of the latched frame.
    function automatic logic pad_at(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return padding_reg & ((r == '0) || ({1'b0, r} == last_reg) ||
                              (c == '0) || ({1'b0, c} == last_reg));
    endfunction

    // Scan FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_reg     <= ST_IDLE;
            last_reg      <= '0;
            padding_reg   <= 1'b0;
            win_valid_o   <= 1'b0;
            row_o         <= '0;
            col_o         <= '0;
            pad_o         <= 1'b0;
            mode_o        <= '0;
            ctrl_reset_o  <= 1'b0;
            ctrl_update_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            ctrl_reset_o  <= 1'b0;
            ctrl_update_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            last_reg     <= last_next;
                            padding_reg  <= padding_i;
                            mode_o       <= mode_i;
                            row_o        <= '0;
                            col_o        <= '0;
                            ctrl_reset_o <= 1'b1;
                            busy_o       <= 1'b1;
                            state_reg    <= ST_LOAD;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    win_valid_o <= 1'b1;
                    pad_o       <= padding_reg;   // (0,0) is always a border window
                    state_reg   <= ST_RUN;
                end
                ST_RUN: begin
                    if (transfer) begin
                        if (col_last) begin
                            col_o         <= '0;
                            ctrl_update_o <= 1'b1;
                            if (row_last) begin
                                row_o       <= '0;
                                pad_o       <= 1'b0;
                                win_valid_o <= 1'b0;
                                done_o      <= 1'b1;
                                state_reg   <= ST_DONE;
                            end else begin
                                row_o <= row_inc;
                                pad_o <= pad_at(row_inc, '0);
                            end
                        end else begin
                            col_o <= col_inc;
                            pad_o <= pad_at(row_o, col_inc);
                        end
                    end
                end
                ST_DONE: begin
                    busy_o    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef IB_SCAN_STALL_CNT_EN
    logic [STALL_W-1:0] stall_reg;

    // Saturating count of RUN cycles where the consumer held ready low.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            stall_reg <= '0;
        end else if (state_reg == ST_LOAD) begin
            stall_reg <= '0;
        end else if ((state_reg == ST_RUN) && !win_ready_i && (stall_reg != '1)) begin
            stall_reg <= stall_reg + STALL_W'(1);
        end
    end

    assign stall_cnt_o = stall_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ib_scan_ctrl.sv
// tb_ib_scan_ctrl: directed bench for ib_scan_ctrl with a window scoreboard.
// Compiles with or without IB_SCAN_STALL_CNT_EN; expected stall counts follow it.
module tb_ib_scan_ctrl;

    localparam int DIM_W   = 6;
    localparam int STALL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic [3:0]         mode_i;
    logic [DIM_W-1:0]   pic_size_i;
    logic               padding_i;
    logic               win_ready_i;
    logic               win_valid_o;
    logic [DIM_W-1:0]   row_o;
    logic [DIM_W-1:0]   col_o;
    logic               pad_o;
    logic [3:0]         mode_o;
    logic               ctrl_reset_o;
    logic               ctrl_update_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [STALL_W-1:0] stall_cnt_o;

    typedef struct packed {
        logic [DIM_W-1:0] r;
        logic [DIM_W-1:0] c;
        logic             p;
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    ib_scan_ctrl #(.DIM_W(DIM_W), .STALL_W(STALL_W)) dut (
        .SYS_CLK      (clk),
        .SYS_NRST     (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .pic_size_i   (pic_size_i),
        .padding_i    (padding_i),
        .win_ready_i  (win_ready_i),
        .win_valid_o  (win_valid_o),
        .row_o        (row_o),
        .col_o        (col_o),
        .pad_o        (pad_o),
        .mode_o       (mode_o),
        .ctrl_reset_o (ctrl_reset_o),
        .ctrl_update_o(ctrl_update_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'(win_valid_o | (|row_o) | (|col_o) | pad_o | (|mode_o) | ctrl_reset_o |
                   ctrl_update_o | busy_o | done_o | err_o | (|stall_cnt_o));
    endfunction

    // One frame: start, scoreboard every window, check update/done timing.
    task automatic run_frame(input int pic, input bit pad, input logic [3:0] mode,
                             input int sr, input int sc, input int slen, input bit inj);
        int   n;
        int   k;
        int   held;
        bit   exp_upd;
        bit   exp_done;
        bit   fin;
        bit   rdy;
        win_t front;
        n = pic - 2 + 2 * int'(pad);
        exp_q.delete();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                exp_q.push_back('{r: DIM_W'(r), c: DIM_W'(c),
                                  p: pad & (r == 0 || r == n-1 || c == 0 || c == n-1)});
        start_i = 1'b1; pic_size_i = DIM_W'(pic); padding_i = pad; mode_i = mode;
        win_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 1;
        chk("load_ctrl_reset", 32'(ctrl_reset_o), 1);
        chk("load_busy", 32'(busy_o), 1);
        chk("load_valid", 32'(win_valid_o), 0);
        chk("load_update", 32'(ctrl_update_o), 0);
        chk("load_mode", 32'(mode_o), 32'(mode));
        held = 0; exp_upd = 0; exp_done = 0; fin = 0;
        while (!fin && k < 300) begin
            @(negedge clk);
            k++;
            start_i = 1'b0;
            chk("ctrl_update", 32'(ctrl_update_o), 32'(exp_upd));
            chk("done", 32'(done_o), 32'(exp_done));
            chk("busy", 32'(busy_o), 1);
            chk("ctrl_reset", 32'(ctrl_reset_o), 0);
            chk("win_valid", 32'(win_valid_o), 32'(exp_q.size() > 0));
            if (exp_done) begin
                fin = 1;
                chk("done_cycle", 32'(k), 32'(n * n + 2 + slen));
            end else if (exp_q.size() > 0) begin
                exp_upd = 0;
                front = exp_q[0];
                chk("row", 32'(row_o), 32'(front.r));
                chk("col", 32'(col_o), 32'(front.c));
                chk("pad", 32'(pad_o), 32'(front.p));
                rdy = !(int'(front.r) == sr && int'(front.c) == sc && held < slen);
                if (!rdy) held++;
                if (inj && k == 4) begin
                    start_i = 1'b1; pic_size_i = DIM_W'(pic + 2);
                end
                win_ready_i = rdy;
                if (rdy) begin
                    void'(exp_q.pop_front());
                    if (int'(front.c) == n - 1) exp_upd = 1;
                    if (exp_q.size() == 0) exp_done = 1;
                end
            end
        end
        if (!fin) chk("frame_timeout", 0, 1);
        win_ready_i = 1'b1;
`ifdef IB_SCAN_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt_o), 32'(slen));
`else
        chk("stall_cnt", 32'(stall_cnt_o), 0);
`endif
        @(negedge clk);
        chk("busy_after_done", 32'(busy_o), 0);
        chk("update_after_done", 32'(ctrl_update_o), 0);
        $display("frame pic=%0d pad=%0d N=%0d stall=%0d done at cycle %0d", pic, pad, n, slen, k);
    endtask

    initial begin
        int   k;
        bit   hit;
        rst_n = 1'b0; start_i = 1'b0; mode_i = '0; pic_size_i = '0;
        padding_i = 1'b0; win_ready_i = 1'b1;
        #1;
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        chk("reset_outputs_held", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3x3 scan, no padding, ready always high.
        run_frame(5, 1'b0, 4'b0001, -1, -1, 0, 1'b0);
        // Padded 4x4 scan, started in the first legal cycle after the previous frame.
        run_frame(4, 1'b1, 4'b0010, -1, -1, 0, 1'b0);

        // Illegal configuration: error pulse only.
        start_i = 1'b1; pic_size_i = DIM_W'(2); padding_i = 1'b0; mode_i = 4'b1000;
        @(negedge clk);
        start_i = 1'b0;
        chk("err_pulse", 32'(err_o), 1);
        chk("err_no_reset", 32'(ctrl_reset_o), 0);
        chk("err_no_busy", 32'(busy_o), 0);
        chk("err_mode_kept", 32'(mode_o), 32'(4'b0010));
        @(negedge clk);
        chk("err_cleared", 32'(err_o), 0);
        chk("err_still_idle", 32'(busy_o), 0);
        $display("illegal config pic=2 pad=0 rejected");

        // Backpressure: ready low for 3 cycles at window (0,1).
        run_frame(5, 1'b0, 4'b0100, 0, 1, 3, 1'b0);
        // Start during RUN with a different size is ignored.
        run_frame(5, 1'b0, 4'b0001, -1, -1, 0, 1'b1);
        // N = 1 boundary, with and without padding.
        run_frame(3, 1'b0, 4'b0001, -1, -1, 0, 1'b0);
        run_frame(1, 1'b1, 4'b0010, -1, -1, 0, 1'b0);

        // Reset asserted while window (1,0) is presented.
        start_i = 1'b1; pic_size_i = DIM_W'(5); padding_i = 1'b0; mode_i = 4'b0100;
        @(negedge clk);
        start_i = 1'b0;
        hit = 0;
        for (k = 0; k < 30 && !hit; k++) begin
            @(negedge clk);
            hit = win_valid_o && row_o == DIM_W'(1) && col_o == DIM_W'(0);
        end
        chk("reach_window_1_0", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", all_outs(), 0);
        hit = 0;
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_o) hit = 1;
        end
        chk("no_done_in_reset", 32'(hit), 0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("mid-frame reset at window (1,0) cleared outputs");
        run_frame(5, 1'b0, 4'b0001, -1, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ib_scan_ctrl.md
# ib_scan_ctrl

Frame scan sequencer for the input buffer. It walks the 3x3 convolution window over one output feature map in row-major order and hands window positions to the window datapath over a valid/ready handshake. It also generates the `ctrl_reset` and `ctrl_update` pulses that drive the downstream 6:1 row-mux controller. It sits directly upstream of that controller and receives the same `mode`, `pic_size` and `padding` configuration, latched per frame.

## Interface
Parameters:
- `DIM_W`, default 6: width of `pic_size` and of the row/column indices.
- `STALL_W`, default 16: width of the stall counter.

Ports:
- `SYS_CLK`, in, 1: system clock, rising edge.
- `SYS_NRST`, in, 1: asynchronous active-low reset.
- `start_i`, in, 1: frame start pulse; honoured only in IDLE.
- `mode_i`, in, 4: one-hot mode; latched at start.
- `pic_size_i`, in, DIM_W: input picture edge length; latched at start.
- `padding_i`, in, 1: 1 = one-pixel zero padding; latched at start.
- `win_ready_i`, in, 1: downstream accepts the current window.
- `win_valid_o`, out, 1: the window position on `row_o`/`col_o` is valid.
- `row_o`, out, DIM_W: output row index of the current window.
- `col_o`, out, DIM_W: output column index of the current window.
- `pad_o`, out, 1: the current window overlaps the padding border.
- `mode_o`, out, 4: latched mode, fed to the mux controller.
- `ctrl_reset_o`, out, 1: one-cycle pulse at frame load.
- `ctrl_update_o`, out, 1: one-cycle pulse per completed output row.
- `busy_o`, out, 1: high from LOAD through DONE.
- `done_o`, out, 1: one-cycle pulse at frame end.
- `err_o`, out, 1: one-cycle pulse when the configuration is illegal.
- `stall_cnt_o`, out, STALL_W: count of RUN cycles lost to backpressure.

## Operation
**Derived size.**
- N = pic_size − 2 + 2·padding.
- Computed in DIM_W+1 bits, unsigned, at start.
- The configuration is illegal if pic_size + 2·padding < 3.

**States and transitions.**
- IDLE: waits for `start_i`.
  - Legal configuration: latch config, go to LOAD.
  - Illegal configuration: pulse `err_o`, stay in IDLE.
- LOAD: one cycle.
  - `ctrl_reset_o` = 1; row and column counters cleared.
  - Go to RUN.
- RUN: `win_valid_o` = 1.
  - A transfer occurs when `win_valid_o` & `win_ready_i`.
  - On transfer, `col` increments.
  - At col = N−1, `col` wraps to 0, `row` increments, and `ctrl_update_o` pulses on the next cycle.
  - A transfer at row = N−1, col = N−1 goes to DONE.
- DONE: one cycle.
  - `done_o` = 1, coincident with the final `ctrl_update_o`.
  - Go to IDLE.

**Per-frame totals.** Exactly N² transfers and N `ctrl_update_o` pulses.

**pad_o.**
- Equals padding & (row = 0 | row = N−1 | col = 0 | col = N−1).
- Always 0 when padding = 0.

**Other behaviour.**
- `mode_o` holds the latched mode until the next accepted start.
- `start_i` outside IDLE is ignored and leaves the config latches unchanged.

## Timing
- **Reset:** every output resets to 0; state resets to IDLE.
- **Start latency:** start at cycle t → `ctrl_reset_o` and `busy_o` at t+1 → `win_valid_o` at t+2.
- **Handshake:**
  - `row_o`, `col_o` and `pad_o` are registered and stable while `win_valid_o` & !`win_ready_i`.
  - `win_valid_o` never drops in RUN without a transfer.
  - Ready held high gives one window per cycle.
- **ctrl_update_o:** asserted in the cycle after the last-column transfer; never during LOAD.
- **End of frame:**
  - `busy_o` falls in the cycle after DONE.
  - A new `start_i` is accepted in that cycle at the earliest.
- **N = 1:** a single transfer, then DONE with one update.
- **Reset mid-frame:** everything returns to IDLE immediately; no `done_o` is produced.

## Configuration
Macro `IB_SCAN_STALL_CNT_EN`.
- **Defined:**
  - `stall_cnt_o` counts RUN cycles with `win_ready_i` = 0.
  - It clears on LOAD and saturates at all-ones.
  - It holds its value after DONE.
- **Undefined:** `stall_cnt_o` is tied to 0 and no counter logic is built.

## Test plan
- pic_size = 5, padding = 0, ready always 1:
  - N = 3; 9 windows on consecutive cycles; `pad_o` always 0.
  - `ctrl_update_o` at cycles t+5, t+8 and t+11; `done_o` at t+11.
- pic_size = 4, padding = 1:
  - N = 4; 16 windows; `pad_o` = 0 only at (1,1), (1,2), (2,1), (2,2).
  - 4 update pulses.
- pic_size = 2, padding = 0:
  - `err_o` pulses at t+1; no `ctrl_reset_o`; `busy_o` stays 0.
- Backpressure with ready low for 3 cycles at (0,1):
  - `row_o`/`col_o` hold (0,1); completion is delayed by 3 cycles.
  - With the macro defined, `stall_cnt_o` = 3.
- `start_i` during RUN with a different pic_size:
  - Ignored; the frame completes with the original N.
- `SYS_NRST` asserted at window (1,0):
  - All outputs go to 0 immediately.
  - A fresh start afterwards runs a full frame.
